// File: rtl/weight_sram_load_ctrl.sv
// weight_sram_load_ctrl
//
// Sequences the load (write) phase of the weight SRAM bank array. Weight
// words arrive on a valid/ready stream. They are scattered across NUM_BANK
// banks with the bank index advancing first and the row advancing on each
// bank wrap. Each accepted word becomes a single-bank write strobe one cycle
// later. When the load finishes, the array is handed back to the read side
// and done pulses for one cycle.
//
// Handshake: a word transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready depends only on controller state, never on
// in_valid. The producer holds in_data and in_valid until the transfer.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start, num_words       start pulse; word count sampled when start is accepted
//   in_valid/in_ready/in_data   weight word stream
//   weight_SRAM_rw_select  1 = write side owns the array
//   weight_SRAM_A_write    per-bank write address (holds between writes)
//   weight_SRAM_CEN_write  per-bank chip enable, active low
//   weight_SRAM_WEN_write  per-bank write enable, active low
//   weight_SRAM_D_write    write data, broadcast to every bank
//   busy, done             load in progress / one-cycle completion pulse
//   stall_cycles           (WSRAM_LOAD_STALL_CNT_EN only) count of LOAD cycles
//                          where the controller was ready but no word was offered
//   dbg_state              current FSM state (IDLE=0, LOAD=1, FLUSH=2, DONE=3)
//
// Optional feature macro: WSRAM_LOAD_STALL_CNT_EN
module weight_sram_load_ctrl #(
  parameter int NUM_BANK = 288,
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              weight_SRAM_rw_select,
  output logic [ADDR_W-1:0] weight_SRAM_A_write   [0:NUM_BANK-1],
  output logic              weight_SRAM_CEN_write [0:NUM_BANK-1],
  output logic              weight_SRAM_WEN_write [0:NUM_BANK-1],
  output logic [DATA_W-1:0] weight_SRAM_D_write,
  output logic              busy,
  output logic              done,
`ifdef WSRAM_LOAD_STALL_CNT_EN
  output logic [CNT_W-1:0]  stall_cycles,
`endif
  output logic [1:0]        dbg_state
);

  localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam logic [CNT_W-1:0] TOTAL_WORDS = CNT_W'(NUM_BANK * DEPTH);
  localparam logic [BANK_W-1:0] LAST_BANK  = BANK_W'(NUM_BANK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  eff;
  logic [CNT_W-1:0]  count;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] row;

  logic              start_acc;
  logic              hs;
  logic              last_hs;
  logic [CNT_W-1:0]  eff_next;

  // Requests beyond the array capacity are clamped, so row never leaves range.
  assign eff_next  = (num_words > TOTAL_WORDS) ? TOTAL_WORDS : num_words;
  assign start_acc = (state == S_IDLE) && start;
  assign hs        = (state == S_LOAD) && in_valid;
  assign last_hs   = hs && (count == eff - 1'b1);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (eff_next == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (last_hs) state_next = S_FLUSH;
      S_FLUSH: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM-decoded outputs ----------------
  // While in LOAD, count is always below eff, because the last handshake exits LOAD.
  always_comb begin
    in_ready  = (state == S_LOAD);
    done      = (state == S_DONE);
    dbg_state = state;
  end

  // ---------------- datapath and registered outputs ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eff                   <= '0;
      count                 <= '0;
      bank                  <= '0;
      row                   <= '0;
      busy                  <= 1'b0;
      weight_SRAM_rw_select <= 1'b0;
      weight_SRAM_D_write   <= '0;
      for (int b = 0; b < NUM_BANK; b++) begin
        weight_SRAM_A_write[b]   <= '0;
        weight_SRAM_CEN_write[b] <= 1'b1;
        weight_SRAM_WEN_write[b] <= 1'b1;
      end
    end else begin
      if (start_acc) begin
        eff   <= eff_next;
        count <= '0;
        bank  <= '0;
        row   <= '0;
        busy  <= 1'b1;
        // A zero-length load never takes the array from the read side.
        weight_SRAM_rw_select <= (eff_next != '0);
      end

      if (hs) begin
        count               <= count + 1'b1;
        weight_SRAM_D_write <= in_data;
        if (bank == LAST_BANK) begin
          bank <= '0;
          row  <= row + 1'b1;
        end else begin
          bank <= bank + 1'b1;
        end
      end

      // The strobes are a one-hot decode of the current bank, and only on a
      // handshake cycle. They fall back to idle in every other cycle.
      for (int b = 0; b < NUM_BANK; b++) begin
        weight_SRAM_CEN_write[b] <= !(hs && (bank == BANK_W'(b)));
        weight_SRAM_WEN_write[b] <= !(hs && (bank == BANK_W'(b)));
        if (hs && (bank == BANK_W'(b)))
          weight_SRAM_A_write[b] <= row;
      end

      // The final strobe is on the bus during FLUSH. The select is released
      // on the same edge that clears that strobe.
      if (state == S_FLUSH) weight_SRAM_rw_select <= 1'b0;
      if (state == S_DONE)  busy <= 1'b0;
    end
  end

`ifdef WSRAM_LOAD_STALL_CNT_EN
  // Counts producer starvation while loading, saturating at all ones.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (start_acc)
      stall_cycles <= '0;
    else if ((state == S_LOAD) && !in_valid && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule
